// File: rtl/tag_lookup_pkg.sv
// Shared types and default geometry for the direct-mapped tag lookup controller.
// The controller takes its widths as parameters; these localparams describe the default build.
package tag_lookup_pkg;

  localparam int AWIDTH_DEF = 3;
  localparam int DWIDTH_DEF = 14;
  localparam int TWIDTH     = DWIDTH_DEF - 1;
  localparam int DEPTH      = 1 << AWIDTH_DEF;
  localparam int VALID_BIT  = DWIDTH_DEF - 1;

  typedef enum logic [2:0] {
    FLUSH = 3'd0,
    IDLE  = 3'd1,
    RD    = 3'd2,
    CMP   = 3'd3,
    WR    = 3'd4
  } state_e;

endpackage

// File: rtl/tag_cmp.sv
// Combinational hit detect for one way: the entry must be valid and its full tag must match.
module tag_cmp #(
  parameter int DWIDTH = 14
) (
  input  logic [DWIDTH-1:0] entry,
  input  logic [DWIDTH-2:0] tag,
  output logic              hit
);

  assign hit = entry[DWIDTH-1] && (entry[DWIDTH-2:0] == tag);

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Serialises flushes, fills and lookups onto one synchronous-read tag RAM port.
// The RAM lives in the parent; this block only drives its address/data/write-enable.
module tag_lookup_ctrl
  import tag_lookup_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_req,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [AWIDTH-1:0] fill_index,
  input  logic [DWIDTH-2:0] fill_tag,
  input  logic              lkp_valid,
  output logic              lkp_ready,
  input  logic [AWIDTH-1:0] lkp_index,
  input  logic [DWIDTH-2:0] lkp_tag,
  input  logic              lkp_alloc,
  output logic              res_valid,
  output logic              res_hit,
  output logic [AWIDTH-1:0] res_index,
  output logic              busy,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  localparam logic [AWIDTH-1:0] CNT_LAST = AWIDTH'((1 << AWIDTH) - 1);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [DWIDTH-2:0] tag_q, tag_d;
  logic              alloc_q, alloc_d;
  logic              res_valid_q, res_valid_d;
  logic              res_hit_q, res_hit_d;
  logic [AWIDTH-1:0] res_index_q, res_index_d;
  logic              hit;

  tag_cmp #(.DWIDTH(DWIDTH)) u_cmp (
    .entry (ram_dout),
    .tag   (tag_q),
    .hit   (hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FLUSH;
      cnt_q       <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      alloc_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      alloc_q     <= alloc_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_index_q <= res_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    alloc_d     = alloc_q;
    res_valid_d = 1'b0;
    res_hit_d   = res_hit_q;
    res_index_d = res_index_q;
    ram_addr    = '0;
    ram_din     = '0;
    ram_we      = 1'b0;
    fill_ready  = 1'b0;
    lkp_ready   = 1'b0;

    unique case (state_q)
      FLUSH: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        cnt_d    = cnt_q + AWIDTH'(1);
        if (cnt_q == CNT_LAST) state_d = IDLE;
      end
      IDLE: begin
        // Flush beats fill beats lookup; ready reflects that priority.
        fill_ready = !flush_req;
        lkp_ready  = !flush_req && !fill_valid;
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (fill_valid) begin
          idx_d   = fill_index;
          tag_d   = fill_tag;
          alloc_d = 1'b0;
          state_d = WR;
        end else if (lkp_valid) begin
          idx_d   = lkp_index;
          tag_d   = lkp_tag;
          alloc_d = lkp_alloc;
          state_d = RD;
        end
      end
      RD: begin
        ram_addr = idx_q;
        state_d  = CMP;
      end
      CMP: begin
        ram_addr    = idx_q;
        res_valid_d = 1'b1;
        res_hit_d   = hit;
        res_index_d = idx_q;
        state_d     = (!hit && alloc_q) ? WR : IDLE;
      end
      WR: begin
        ram_we   = 1'b1;
        ram_addr = idx_q;
        ram_din  = {1'b1, tag_q};
        state_d  = IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end

  assign res_valid = res_valid_q;
  assign res_hit   = res_hit_q;
  assign res_index = res_index_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Scoreboard bench for tag_lookup_ctrl: stimulus queues expected results and RAM writes,
// independent negedge monitors pop and compare whenever the DUT strobes them.
module tb_tag_lookup_ctrl;

  localparam int AW = 3;
  localparam int DW = 14;
  localparam int TW = DW - 1;

  typedef struct {
    logic          hit;
    logic [AW-1:0] idx;
    int            cyc;
  } res_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush_req = 1'b0;
  logic          fill_valid = 1'b0;
  logic          fill_ready;
  logic [AW-1:0] fill_index = '0;
  logic [TW-1:0] fill_tag = '0;
  logic          lkp_valid = 1'b0;
  logic          lkp_ready;
  logic [AW-1:0] lkp_index = '0;
  logic [TW-1:0] lkp_tag = '0;
  logic          lkp_alloc = 1'b0;
  logic          res_valid;
  logic          res_hit;
  logic [AW-1:0] res_index;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  res_t res_q[$];
  wr_t  wr_q[$];
  int   cycle = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  tag_lookup_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock(clock), .reset(reset), .flush_req(flush_req),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_index(fill_index), .fill_tag(fill_tag),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
    .lkp_alloc(lkp_alloc), .res_valid(res_valid), .res_hit(res_hit), .res_index(res_index),
    .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Synchronous-read tag RAM as the parent would instantiate it.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
    cycle <= cycle + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    res_t e;
    wr_t  w;
    if (res_valid) begin
      if (res_q.size() == 0) begin
        check_output("unexpected_result", 32'(res_index), 32'hFFFF_FFFF);
      end else begin
        e = res_q.pop_front();
        check_output("res_hit", 32'(res_hit), 32'(e.hit));
        check_output("res_index", 32'(res_index), 32'(e.idx));
        check_output("res_latency_cycle", 32'(cycle), 32'(e.cyc));
      end
    end
    if (!reset && ram_we) begin
      if (wr_q.size() == 0) begin
        check_output("unexpected_write_addr", 32'(ram_addr), 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        check_output("wr_addr", 32'(ram_addr), 32'(w.addr));
        check_output("wr_din", 32'(ram_din), 32'(w.data));
      end
    end
  end

  task automatic push_flush();
    for (int i = 0; i < (1 << AW); i++) wr_q.push_back('{addr: AW'(i), data: '0});
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic apply_fill(input logic [AW-1:0] idx, input logic [TW-1:0] tag);
    int guard = 0;
    fill_valid = 1'b1; fill_index = idx; fill_tag = tag;
    while (!fill_ready && guard < 50) begin guard++; @(negedge clock); end
    check_output("fill_accept_timeout", 32'(fill_ready), 32'd1);
    if (fill_ready) wr_q.push_back('{addr: idx, data: {1'b1, tag}});
    @(posedge clock);
    @(negedge clock);
    fill_valid = 1'b0;
  endtask

  task automatic apply_lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                              input logic alloc, input logic exp_hit);
    int guard = 0;
    lkp_valid = 1'b1; lkp_index = idx; lkp_tag = tag; lkp_alloc = alloc;
    while (!lkp_ready && guard < 50) begin guard++; @(negedge clock); end
    check_output("lkp_accept_timeout", 32'(lkp_ready), 32'd1);
    if (lkp_ready) begin
      res_q.push_back('{hit: exp_hit, idx: idx, cyc: cycle + 3});
      if (alloc && !exp_hit) wr_q.push_back('{addr: idx, data: {1'b1, tag}});
    end
    @(posedge clock);
    @(negedge clock);
    lkp_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_output("rst_res_valid", 32'(res_valid), 32'd0);
    check_output("rst_res_hit", 32'(res_hit), 32'd0);
    check_output("rst_res_index", 32'(res_index), 32'd0);
    check_output("rst_fill_ready", 32'(fill_ready), 32'd0);
    check_output("rst_lkp_ready", 32'(lkp_ready), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd1);
    check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_output("rst_ram_din", 32'(ram_din), 32'd0);
  endtask

  task automatic release_reset_and_flush();
    int n;
    push_flush();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    wait_idle(n);
    check_output("flush_cycles", 32'(n), 32'd8);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    // Reset and the initial flush.
    repeat (3) @(negedge clock);
    check_reset_outputs();
    release_reset_and_flush();
    check_output("idle_lkp_ready", 32'(lkp_ready), 32'd1);
    check_output("idle_busy", 32'(busy), 32'd0);

    // Fill then hit.
    apply_fill(3'd3, 13'h0AB);
    apply_lookup(3'd3, 13'h0AB, 1'b0, 1'b1);

    // Non-allocating miss, allocating miss, then hit on the allocated tag.
    apply_lookup(3'd3, 13'h0AC, 1'b0, 1'b0);
    apply_lookup(3'd3, 13'h0AC, 1'b1, 1'b0);
    apply_lookup(3'd3, 13'h0AC, 1'b0, 1'b1);
    apply_lookup(3'd3, 13'h0AB, 1'b0, 1'b0);
    apply_lookup(3'd2, 13'h000, 1'b0, 1'b0);

    // Fill and lookup together: fill wins, lookup follows and sees it.
    fill_index = 3'd6; fill_tag = 13'h155;
    lkp_index = 3'd6; lkp_tag = 13'h155; lkp_alloc = 1'b0;
    fill_valid = 1'b1; lkp_valid = 1'b1;
    guard = 0;
    while (!fill_ready && guard < 50) begin guard++; @(negedge clock); end
    check_output("both_fill_ready", 32'(fill_ready), 32'd1);
    check_output("both_lkp_ready", 32'(lkp_ready), 32'd0);
    wr_q.push_back('{addr: 3'd6, data: {1'b1, 13'h155}});
    @(posedge clock);
    @(negedge clock);
    fill_valid = 1'b0;
    guard = 0;
    while (!lkp_ready && guard < 50) begin guard++; @(negedge clock); end
    check_output("held_lkp_accept", 32'(lkp_ready), 32'd1);
    res_q.push_back('{hit: 1'b1, idx: 3'd6, cyc: cycle + 3});
    @(posedge clock);
    @(negedge clock);
    lkp_valid = 1'b0;

    // Flush after a fill invalidates it.
    apply_fill(3'd5, 13'h0F0);
    apply_lookup(3'd5, 13'h0F0, 1'b0, 1'b1);
    flush_req = 1'b1;
    guard = 0;
    while (busy && guard < 50) begin guard++; @(negedge clock); end
    check_output("flush_fill_ready", 32'(fill_ready), 32'd0);
    check_output("flush_lkp_ready", 32'(lkp_ready), 32'd0);
    push_flush();
    @(posedge clock);
    @(negedge clock);
    flush_req = 1'b0;
    wait_idle(guard);
    check_output("flush_req_cycles", 32'(guard), 32'd8);
    apply_lookup(3'd5, 13'h0F0, 1'b0, 1'b0);
    apply_lookup(3'd6, 13'h155, 1'b0, 1'b0);

    // Reset while a lookup sits in CMP: its result must never appear.
    apply_lookup(3'd3, 13'h0AB, 1'b0, 1'b0);
    void'(res_q.pop_back());
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs();
    check_output("rst_ram_we", 32'(ram_we), 32'd1);
    release_reset_and_flush();

    guard = 0;
    while ((res_q.size() != 0 || wr_q.size() != 0) && guard < 50) begin
      guard++;
      @(negedge clock);
    end
    check_output("scoreboard_drained", 32'(res_q.size() + wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
